rib_xbar_n: RTL
===============

// Module: rib_xbar_n
// PURPOSE
//  Parametrised successor to the fixed 4-master/6-slave RIB interconnect in the tinyriscv SoC top.
//  Arbitrates NM masters onto NS slaves; the slave is selected by addr[31:28].
//  Adds bus lock while a request is held, a MAX_LOCK starvation limit, decode-error response and per-master hold flags.
// PARAMETERS
//  NM        4            number of masters (2..8); index NM-1 = highest fixed priority
//  NS        6            number of slaves (1..16); slave k owns addr[31:28]==k
//  MAX_LOCK  16           max consecutive cycles one master may own the bus (>=2)
//  ERR_DATA  32'hDEADBEEF read data returned on a decode error
// PORTS
//  clk        in   1      clock
//  rst        in   1      synchronous, active-high reset
//  m_req_i    in   NM     per-master request
//  m_we_i     in   NM     per-master write enable
//  m_addr_i   in   NM*32  master i address at [32*i+:32]
//  m_wdata_i  in   NM*32  master write data
//  m_rdata_o  out  NM*32  read data; only the granted master's slice is valid, others are 0
//  m_hold_o   out  NM     request pending but not granted this cycle
//  s_addr_o   out  32     {4'h0, addr[27:0]} of the granted master; 0 when idle
//  s_wdata_o  out  32     write data of the granted master
//  s_we_o     out  NS     one-hot write strobe to the decoded slave
//  s_rdata_i  in   NS*32  slave read data
//  dec_err_o  out  1      registered 1-cycle pulse after a granted access with addr[31:28]>=NS
// BEHAVIOUR
//  - Reset: state=IDLE, owner_q=0, lock_cnt=0, excl_q=0, dec_err_o=0, rr_ptr=0; all outputs 0.
//  - States: IDLE (no owner) and OWNED (owner_q holds the bus).
//  - IDLE: winner = highest-index req not masked by excl_q, chosen combinationally.
//    The winner's access is forwarded in the same cycle (zero latency).
//    Next cycle: OWNED, owner_q=winner, lock_cnt=1. No requests: stay IDLE.
//  - OWNED: owner_q forwarded regardless of other requests.
//    owner req low -> IDLE next cycle; that cycle forwards nothing.
//    Otherwise lock_cnt increments.
//  - Starvation limit: lock_cnt==MAX_LOCK and another master requesting -> force IDLE, set excl_q=owner one-hot.
//    excl_q masks that master for exactly one arbitration, then clears.
//    If no other master is requesting, the lock continues and lock_cnt saturates at MAX_LOCK.
//  - m_hold_o[i] = m_req_i[i] & ~(i is the master being forwarded this cycle).
//  - Read path: m_rdata_o[owner] = s_rdata_i[sel] combinationally, or ERR_DATA when sel>=NS.
//    s_we_o is all-zero when sel>=NS, so a bad write is dropped.
//  - Simultaneous drop and new requests: the release cycle is idle and arbitration occurs the following cycle.
//  - Reset mid-transfer: ownership is abandoned; s_we_o is 0 in the reset cycle.
// CONFIGURATION
//  RIB_XBAR_RR_EN defined: IDLE arbitration is round-robin from rr_ptr.
//    rr_ptr = winner+1 (mod NM) on each grant; excl_q still applies.
//  Undefined: fixed priority, highest index wins; no rr_ptr flop.
// STRUCTURE
//  Shared package/defines (rib_defs.vh): RIB_SEL_MSB=31, RIB_SEL_LSB=28, RIB_AW=32, RIB_DW=32, state encodings.
//  One sub-module: rib_arb_pick (NM-wide request vector + mask (+rr_ptr) -> one-hot/index winner, valid); purely combinational.
//  Top-level: FSM, lock counter, excl_q, decode mux, error register.
// TESTING
//  1. NM=4, m1 reads 0x1000_0004 alone -> s_addr_o=0x0000_0004 same cycle; m_rdata_o[1]=s_rdata_i[1]; m_hold_o=0.
//  2. m0 and m3 both request in IDLE -> m3 granted; m_hold_o=4'b0001 until m3 drops req.
//     IDLE gap of 1 cycle, then m0 granted.
//  3. m2 locked while m3 requests: m2 keeps the bus (m_hold_o[3]=1) until the MAX_LOCK=16th cycle.
//     Then forced release; m3 wins even if m2 still requests.
//  4. m0 writes to 0x7000_0000 (NS=6) -> s_we_o=0; dec_err_o=1 for one cycle; read to same address returns 0xDEADBEEF.
//  5. rst asserted during an OWNED write -> next cycle all outputs 0, state IDLE.
//     m1 requesting after rst drops is granted immediately.
//  6. RIB_XBAR_RR_EN: all four masters request continuously with single-cycle drops -> grants rotate 0,1,2,3,0.
//     Without the macro, grants stay on m3.

Source files
------------

// File: rtl/rib_xbar_n_pkg.sv
// rib_xbar_n_pkg: constants, FSM encoding and one helper shared by the crossbar files.
//   RIB_AW / RIB_DW          address and data widths of every RIB port
//   RIB_SEL_MSB / RIB_SEL_LSB address field that selects the slave
//   rib_state_e              arbiter FSM states (idle / owned)
//   rib_slave_addr()         strips the slave-select field from a master address
package rib_xbar_n_pkg;

  localparam int unsigned RIB_AW      = 32;
  localparam int unsigned RIB_DW      = 32;
  localparam int unsigned RIB_SEL_MSB = 31;
  localparam int unsigned RIB_SEL_LSB = 28;
  localparam int unsigned RIB_SEL_W   = RIB_SEL_MSB - RIB_SEL_LSB + 1;

  typedef enum logic {
    StIdle  = 1'b0,
    StOwned = 1'b1
  } rib_state_e;

  // Slaves see a local address: the select field is zeroed.
  function automatic logic [RIB_AW-1:0] rib_slave_addr(input logic [RIB_AW-1:0] addr);
    logic [RIB_AW-1:0] local_addr;
    local_addr = addr;
    local_addr[RIB_SEL_MSB:RIB_SEL_LSB] = '0;
    return local_addr;
  endfunction

endpackage

// File: rtl/rib_xbar_n_arb_pick.sv
// rib_xbar_n_arb_pick: purely combinational winner selection for the RIB crossbar.
// Optional feature macro: RIB_XBAR_RR_EN (round-robin search starting at i_rr_ptr);
// without it the highest-index eligible request wins.
// Ports:
//   i_req     NM   request vector
//   i_mask    NM   masters excluded from this arbitration
//   i_rr_ptr  IW   round-robin start index (only with RIB_XBAR_RR_EN)
//   o_onehot  NM   one-hot winner (0 when none)
//   o_idx     IW   winner index (0 when none)
//   o_valid   1    a winner exists
module rib_xbar_n_arb_pick #(
  parameter int unsigned NM = 4,
  parameter int unsigned IW = 2
) (
  input  logic [NM-1:0] i_req,
  input  logic [NM-1:0] i_mask,
`ifdef RIB_XBAR_RR_EN
  input  logic [IW-1:0] i_rr_ptr,
`endif
  output logic [NM-1:0] o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  logic [NM-1:0] w_cand;
  assign w_cand = i_req & ~i_mask;

`ifdef RIB_XBAR_RR_EN
  logic [2*NM-1:0] w_dbl;
  logic [NM-1:0]   w_rot;
  logic [IW-1:0]   w_off;
  logic [IW:0]     w_sum;

  // Rotate candidates so that bit 0 is the master at i_rr_ptr, then take the lowest set bit.
  always_comb begin
    w_dbl   = {w_cand, w_cand} >> i_rr_ptr;
    w_rot   = w_dbl[NM-1:0];
    w_off   = '0;
    o_valid = 1'b0;
    for (int k = NM - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_valid = 1'b1;
        w_off   = IW'(k);
      end
    end
    w_sum = {1'b0, i_rr_ptr} + {1'b0, w_off};
    if (w_sum >= (IW+1)'(NM)) begin
      w_sum = w_sum - (IW+1)'(NM);
    end
    o_idx = o_valid ? w_sum[IW-1:0] : '0;
  end
`else
  // Later (higher-index) hits overwrite earlier ones.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    for (int i = 0; i < NM; i++) begin
      if (w_cand[i]) begin
        o_valid = 1'b1;
        o_idx   = IW'(i);
      end
    end
  end
`endif

  always_comb begin
    o_onehot        = '0;
    o_onehot[o_idx] = o_valid;
  end

endmodule

// File: rtl/rib_xbar_n.sv
// rib_xbar_n: NM-master / NS-slave RIB crossbar with bus lock, starvation limit and decode error.
// Optional feature macro: RIB_XBAR_RR_EN (round-robin idle arbitration; default fixed priority,
// highest master index wins).
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   m_req_i      NM      per-master request
//   m_we_i       NM      per-master write enable
//   m_addr_i     NM*32   master i address at [32*i+:32]
//   m_wdata_i    NM*32   master write data
//   m_rdata_o    NM*32   read data to the forwarded master, 0 for all others
//   m_hold_o     NM      request pending but not forwarded this cycle
//   s_addr_o     32      forwarded address with select field zeroed, 0 when idle
//   s_wdata_o    32      forwarded write data, 0 when idle
//   s_we_o       NS      one-hot write strobe to the decoded slave
//   s_rdata_i    NS*32   slave read data
//   dec_err_o    1       registered pulse after a forwarded access to a non-existent slave
module rib_xbar_n
  import rib_xbar_n_pkg::*;
#(
  parameter int unsigned    NM       = 4,
  parameter int unsigned    NS       = 6,
  parameter int unsigned    MAX_LOCK = 16,
  parameter logic [RIB_DW-1:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NM-1:0]        m_req_i,
  input  logic [NM-1:0]        m_we_i,
  input  logic [NM*RIB_AW-1:0] m_addr_i,
  input  logic [NM*RIB_DW-1:0] m_wdata_i,
  output logic [NM*RIB_DW-1:0] m_rdata_o,
  output logic [NM-1:0]        m_hold_o,
  output logic [RIB_AW-1:0]    s_addr_o,
  output logic [RIB_DW-1:0]    s_wdata_o,
  output logic [NS-1:0]        s_we_o,
  input  logic [NS*RIB_DW-1:0] s_rdata_i,
  output logic                 dec_err_o
);

  localparam int unsigned IW = $clog2(NM);
  localparam int unsigned CW = $clog2(MAX_LOCK + 1);
  localparam int unsigned SW = RIB_SEL_W;

  rib_state_e    r_state;
  logic [IW-1:0] r_owner;
  logic [CW-1:0] r_lock_cnt;
  logic [NM-1:0] r_excl;
  logic          r_dec_err;
`ifdef RIB_XBAR_RR_EN
  logic [IW-1:0] r_rr_ptr;
`endif

  logic [NM-1:0]     w_pick_oh;
  logic [IW-1:0]     w_pick_idx;
  logic              w_pick_valid;
  logic [NM-1:0]     w_owner_oh;
  logic              w_owner_req;
  logic              w_others_req;
  logic              w_at_limit;
  logic              w_fwd_valid;
  logic [NM-1:0]     w_fwd_oh;
  logic [RIB_AW-1:0] w_addr;
  logic [RIB_DW-1:0] w_wdata;
  logic              w_we;
  logic [SW-1:0]     w_sel;
  logic              w_sel_ok;
  logic [RIB_DW-1:0] w_srdata;

  rib_xbar_n_arb_pick #(
    .NM (NM),
    .IW (IW)
  ) u_arb_pick (
    .i_req    (m_req_i),
    .i_mask   (r_excl),
`ifdef RIB_XBAR_RR_EN
    .i_rr_ptr (r_rr_ptr),
`endif
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx),
    .o_valid  (w_pick_valid)
  );

  always_comb begin
    w_owner_oh          = '0;
    w_owner_oh[r_owner] = 1'b1;
  end

  assign w_owner_req  = |(m_req_i & w_owner_oh);
  assign w_others_req = |(m_req_i & ~w_owner_oh);
  assign w_at_limit   = (r_lock_cnt == CW'(MAX_LOCK));

  // Which master drives the slave side this cycle; nothing is forwarded while in reset.
  always_comb begin
    w_fwd_valid = 1'b0;
    w_fwd_oh    = '0;
    if (!rst) begin
      if (r_state == StIdle) begin
        w_fwd_valid = w_pick_valid;
        w_fwd_oh    = w_pick_oh;
      end else begin
        w_fwd_valid = w_owner_req;
        w_fwd_oh    = w_owner_req ? w_owner_oh : '0;
      end
    end
  end

  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    w_we    = 1'b0;
    for (int i = 0; i < NM; i++) begin
      if (w_fwd_oh[i]) begin
        w_addr  = m_addr_i[i*RIB_AW +: RIB_AW];
        w_wdata = m_wdata_i[i*RIB_DW +: RIB_DW];
        w_we    = m_we_i[i];
      end
    end
  end

  assign w_sel    = w_addr[RIB_SEL_MSB:RIB_SEL_LSB];
  assign w_sel_ok = (32'(w_sel) < NS);

  // Unmatched select falls through to ERR_DATA.
  always_comb begin
    w_srdata = ERR_DATA;
    for (int k = 0; k < NS; k++) begin
      if (w_sel == SW'(k)) begin
        w_srdata = s_rdata_i[k*RIB_DW +: RIB_DW];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NM; i++) begin
      m_rdata_o[i*RIB_DW +: RIB_DW] = w_fwd_oh[i] ? w_srdata : '0;
    end
  end

  // A select beyond NS matches no strobe, so bad writes are dropped.
  always_comb begin
    for (int k = 0; k < NS; k++) begin
      s_we_o[k] = w_we & (w_sel == SW'(k));
    end
  end

  assign s_addr_o  = rib_slave_addr(w_addr);
  assign s_wdata_o = w_wdata;
  assign m_hold_o  = rst ? '0 : (m_req_i & ~w_fwd_oh);
  assign dec_err_o = r_dec_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_owner    <= '0;
      r_lock_cnt <= '0;
      r_excl     <= '0;
      r_dec_err  <= 1'b0;
`ifdef RIB_XBAR_RR_EN
      r_rr_ptr   <= '0;
`endif
    end else begin
      r_dec_err <= w_fwd_valid & ~w_sel_ok;
      unique case (r_state)
        StIdle: begin
          // Exclusion lasts for exactly one idle arbitration.
          r_excl <= '0;
          if (w_pick_valid) begin
            r_state    <= StOwned;
            r_owner    <= w_pick_idx;
            r_lock_cnt <= CW'(1);
`ifdef RIB_XBAR_RR_EN
            r_rr_ptr   <= (w_pick_idx == IW'(NM - 1)) ? '0 : w_pick_idx + IW'(1);
`endif
          end
        end
        StOwned: begin
          if (!w_owner_req) begin
            r_state    <= StIdle;
            r_lock_cnt <= '0;
          end else if (w_at_limit && w_others_req) begin
            r_state    <= StIdle;
            r_excl     <= w_owner_oh;
            r_lock_cnt <= '0;
          end else if (!w_at_limit) begin
            r_lock_cnt <= r_lock_cnt + CW'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
